// File: rtl/shift_left_seq_if.sv
// Start/busy/done handshake and operand/result bus for the iterative left shifter.
interface shift_left_seq_if #(
   parameter int unsigned n = 4
);
   logic          start;
   logic [n-1:0]  a;
   logic [n-1:0]  b;
   logic          busy;
   logic          done;
   logic [n-1:0]  c;
   logic [3:0]    banderas;

   modport master (
      output start, a, b,
      input  busy, done, c, banderas
   );

   modport slave (
      input  start, a, b,
      output busy, done, c, banderas
   );
endinterface

// File: rtl/shift_left_seq.sv
// Iterative logical left shifter: one bit position per clock, with N/Z/C/V flags.
// The accepting edge already performs the first shift, so latency is max(b',1) cycles.
module shift_left_seq #(
   parameter int unsigned n = 4
) (
   input  logic               clk,
   input  logic               rst,
   shift_left_seq_if.slave    bus
);

   localparam int unsigned CW      = $clog2(n + 2);
   localparam int unsigned W       = n;
   localparam logic [W-1:0] MAX_SH = W'(n + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [n-1:0]    acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cc_q, cc_d;
   logic            cv_q, cv_d;
   logic            sgn_q, sgn_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [n-1:0]    c_q, c_d;
   logic [3:0]      banderas_q, banderas_d;

   logic [CW-1:0]   b_eff;
   logic [n-1:0]    step_src;
   logic            step_sgn;
   logic            step_cv;
   logic [n-1:0]    step_acc;
   logic            step_c;
   logic            step_v;

   function automatic logic [3:0] pack_flags(input logic [n-1:0] r,
                                             input logic cf,
                                             input logic vf);
      return {r[n-1], (r == '0), cf, vf};
   endfunction

   // Shift amounts beyond n+1 give the same result and flags as n+1.
   always_comb begin
      b_eff = (bus.b > MAX_SH) ? CW'(n + 1) : CW'(bus.b);
   end

   // One shift step; sourced from the operand on acceptance, else from the accumulator.
   always_comb begin
      step_src = acc_q;
      step_sgn = sgn_q;
      step_cv  = cv_q;
      if (state_q == IDLE) begin
         step_src = bus.a;
         step_sgn = bus.a[n-1];
         step_cv  = 1'b0;
      end
      step_acc = step_src << 1;
      step_c   = step_src[n-1];
      step_v   = step_cv | (step_src[n-2] != step_sgn);
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      cc_d       = cc_q;
      cv_d       = cv_q;
      sgn_d      = sgn_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      c_d        = c_q;
      banderas_d = banderas_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               sgn_d = bus.a[n-1];
               if (b_eff == '0) begin
                  acc_d      = bus.a;
                  cnt_d      = '0;
                  cc_d       = 1'b0;
                  cv_d       = 1'b0;
                  c_d        = bus.a;
                  banderas_d = pack_flags(bus.a, 1'b0, 1'b0);
                  done_d     = 1'b1;
                  state_d    = DONE;
               end else if (b_eff == CW'(1)) begin
                  acc_d      = step_acc;
                  cnt_d      = '0;
                  cc_d       = step_c;
                  cv_d       = step_v;
                  c_d        = step_acc;
                  banderas_d = pack_flags(step_acc, step_c, step_v);
                  done_d     = 1'b1;
                  state_d    = DONE;
               end else begin
                  acc_d   = step_acc;
                  cnt_d   = b_eff - CW'(1);
                  cc_d    = step_c;
                  cv_d    = step_v;
                  busy_d  = 1'b1;
                  state_d = SHIFT;
               end
            end
         end

         SHIFT: begin
            acc_d = step_acc;
            cc_d  = step_c;
            cv_d  = step_v;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               c_d        = step_acc;
               banderas_d = pack_flags(step_acc, step_c, step_v);
               done_d     = 1'b1;
               state_d    = DONE;
            end else begin
               busy_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         cc_q       <= 1'b0;
         cv_q       <= 1'b0;
         sgn_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         c_q        <= '0;
         banderas_q <= 4'b0000;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         cc_q       <= cc_d;
         cv_q       <= cv_d;
         sgn_q      <= sgn_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         c_q        <= c_d;
         banderas_q <= banderas_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.c        = c_q;
   assign bus.banderas = banderas_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq (n=4): directed vectors push expectations,
// a negedge monitor pops and checks them on every done pulse.
module tb_shift_left_seq;

   logic clk;
   logic rst;
   int unsigned cyc;
   int checks;
   int errors;

   shift_left_seq_if #(.n(4)) bus ();

   shift_left_seq #(.n(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  c;
      logic [3:0]  f;
      int unsigned due;
      int unsigned busy_cycles;
   } exp_t;

   exp_t sb[$];
   int unsigned busy_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares each completion against the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_done: got c=%b banderas=%b with nothing pending (cycle %0d)",
                        bus.c, bus.banderas, cyc);
            end else begin
               e = sb.pop_front();
               check("result_c", 32'(bus.c), 32'(e.c));
               check("banderas", 32'(bus.banderas), 32'(e.f));
               check("done_cycle", 32'(cyc), 32'(e.due));
               check("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
               check("busy_at_done", 32'(bus.busy), 32'(0));
            end
            busy_cnt = 0;
         end
      end
   end

   // Entered and left at #1 after a rising edge; waits until the DUT is idle.
   task automatic wait_idle();
      int n_wait;
      n_wait = 0;
      while ((bus.busy || bus.done) && n_wait < 100) begin
         @(posedge clk); #1;
         n_wait++;
      end
      if (bus.busy || bus.done) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: busy=%b done=%b still set after %0d cycles", bus.busy, bus.done, n_wait);
      end
   endtask

   task automatic start_raw(input logic [3:0] a, input logic [3:0] b);
      wait_idle();
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = $urandom_range(0, 15);
      bus.b     = $urandom_range(0, 15);
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_c, input logic [3:0] exp_f,
                        input int unsigned lat, input int unsigned busy_cycles);
      exp_t e;
      wait_idle();
      e.c           = exp_c;
      e.f           = exp_f;
      e.due         = cyc + lat;
      e.busy_cycles = busy_cycles;
      sb.push_back(e);
      start_raw(a, b);
   endtask

   initial begin
      int n_wait;
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_c", 32'(bus.c), 32'(0));
      check("reset_banderas", 32'(bus.banderas), 32'(0));
      check("reset_busy_done", 32'({bus.busy, bus.done}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_after_reset", 32'({bus.busy, bus.done, bus.c, bus.banderas}), 32'(0));

      //     a        b        c        NZCV     lat busy
      issue(4'b0011, 4'd1,  4'b0110, 4'b0000, 1, 0);
      issue(4'b1001, 4'd1,  4'b0010, 4'b0011, 1, 0);
      issue(4'b1111, 4'd2,  4'b1100, 4'b1010, 2, 1);
      issue(4'b0101, 4'd0,  4'b0101, 4'b0000, 1, 0);
      // Sign becomes 1 after the third step, so V is set even though c ends at 0.
      issue(4'b0001, 4'd4,  4'b0000, 4'b0111, 4, 3);
      issue(4'b0001, 4'd9,  4'b0000, 4'b0101, 5, 4);
      issue(4'b0100, 4'd1,  4'b1000, 4'b1001, 1, 0);
      issue(4'b1000, 4'd3,  4'b0000, 4'b0101, 3, 2);
      issue(4'b0000, 4'd15, 4'b0000, 4'b0100, 5, 4);
      issue(4'b1010, 4'd0,  4'b1010, 4'b1000, 1, 0);
      issue(4'b0110, 4'd5,  4'b0000, 4'b0101, 5, 4);
      issue(4'b1101, 4'd4,  4'b0000, 4'b0111, 4, 3);
      issue(4'b0111, 4'd3,  4'b1000, 4'b1011, 3, 2);

      // start during SHIFT and DONE is dropped; c/banderas hold the last result meanwhile.
      issue(4'b1111, 4'd9,  4'b0000, 4'b0101, 5, 4);
      check("busy_after_accept", 32'(bus.busy), 32'(1));
      bus.start = 1'b1;
      bus.a     = 4'b0011;
      bus.b     = 4'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("hold_c_while_busy", 32'(bus.c), 32'(4'b1000));
      check("hold_banderas_while_busy", 32'(bus.banderas), 32'(4'b1011));
      n_wait = 0;
      while (!bus.done && n_wait < 20) begin
         @(posedge clk); #1;
         n_wait++;
      end
      check("done_reached", 32'(bus.done), 32'(1));
      bus.start = 1'b1;
      bus.a     = 4'b0101;
      bus.b     = 4'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("start_in_done_ignored", 32'({bus.busy, bus.done}), 32'(0));

      // Reset in the middle of a shift: outputs clear at once, no completion follows.
      start_raw(4'b0001, 4'd9);
      @(posedge clk); #1;
      check("busy_before_reset", 32'(bus.busy), 32'(1));
      rst = 1'b1;
      #1;
      check("midreset_c", 32'(bus.c), 32'(0));
      check("midreset_banderas", 32'(bus.banderas), 32'(0));
      check("midreset_busy_done", 32'({bus.busy, bus.done}), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("no_busy_after_reset", 32'(bus.busy), 32'(0));

      // Back-to-back operation after reset.
      issue(4'b0011, 4'd2,  4'b1100, 4'b1001, 2, 1);
      issue(4'b0010, 4'd0,  4'b0010, 4'b0000, 1, 0);

      n_wait = 0;
      while (sb.size() != 0 && n_wait < 50) begin
         @(posedge clk); #1;
         n_wait++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
